// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte buffer feeding the UART transmitter over an i_next/o_ready handshake.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 i_divided_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_wr,
  input  logic [WIDTH-1:0]     i_wdata,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_overflow,
  input  logic                 i_clr_overflow,
  input  logic                 i_next,
  output logic                 o_ready,
  output logic [WIDTH-1:0]     o_data
);
  typedef enum logic [1:0] {IDLE, PRESENT, HOLDOFF} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS:0] count_q, count_d;
  logic full_q, empty_q, ovf_q, ovf_d, ready_q, ready_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic push, pop;
  // Full is the registered flag, so a pop in the same cycle never frees room for a write.
  assign push = i_wr && !full_q;
  assign pop = i_en && state_q == PRESENT;
  assign wr_ptr_d = wr_ptr_q + ADDR_BITS'(push);
  assign rd_ptr_d = rd_ptr_q + ADDR_BITS'(pop);
  assign count_d = count_q + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(pop);
  assign ovf_d = (i_wr && full_q) || (ovf_q && !i_clr_overflow);
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    data_d = data_q;
    if (i_en) begin
      case (state_q)
        IDLE: if (i_next && count_q != '0) begin
          data_d = mem[rd_ptr_q];
          ready_d = 1'b1;
          state_d = PRESENT;
        end
        PRESENT: begin
          ready_d = 1'b0;
          state_d = HOLDOFF;
        end
        HOLDOFF: state_d = i_next ? HOLDOFF : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_divided_clk)
    if (push) mem[wr_ptr_q] <= i_wdata;
  always_ff @(posedge i_divided_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      ovf_q <= 1'b0;
      ready_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      full_q <= count_d == (ADDR_BITS+1)'(DEPTH);
      empty_q <= count_d == '0;
      ovf_q <= ovf_d;
      ready_q <= ready_d;
      data_q <= data_d;
    end
  end
  assign o_full = full_q;
  assign o_empty = empty_q;
  assign o_count = count_q;
  assign o_overflow = ovf_q;
  assign o_ready = ready_q;
  assign o_data = data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table plus occupancy model and byte scoreboard for uart_tx_fifo.
module tb_uart_tx_fifo;
  logic clk = 0, rst = 1, en = 0, wr = 0, clr = 0, nxt = 0;
  logic [7:0] wdata = 0;
  logic full, empty, ovf, ready;
  logic [4:0] count;
  logic [7:0] data;
  int checks = 0, errors = 0, occ = 0;
  bit exp_ovf = 0;
  logic [7:0] sb[$];
  typedef struct {logic w; logic [7:0] d; logic n; logic e; logic r; logic [7:0] od;} vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  uart_tx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .i_divided_clk(clk), .i_rst(rst), .i_en(en), .i_wr(wr), .i_wdata(wdata),
    .o_full(full), .o_empty(empty), .o_count(count), .o_overflow(ovf),
    .i_clr_overflow(clr), .i_next(nxt), .o_ready(ready), .o_data(data)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic n, input logic e, input logic c);
    bit acc, pop, rdy_before;
    wr = w; wdata = d; nxt = n; en = e; clr = c;
    rdy_before = ready;
    acc = w && occ < 16;
    pop = e && rdy_before;
    if (acc) sb.push_back(d);
    if (w && !acc) exp_ovf = 1;
    else if (c) exp_ovf = 0;
    @(posedge clk); #1;
    occ = occ + int'(acc) - int'(pop);
    chk("count", count, occ);
    chk("empty", empty, occ == 0);
    chk("full", full, occ == 16);
    chk("overflow", ovf, exp_ovf);
    if (ready && !rdy_before) begin
      if (sb.size() == 0) chk("unexpected_byte", data, -1);
      else chk("byte_order", data, sb.pop_front());
    end
    wr = 0; clr = 0;
  endtask

  initial begin
    tbl[0]  = '{1, 8'hA5, 1, 1, 0, 8'h00};
    tbl[1]  = '{0, 8'h00, 1, 1, 1, 8'hA5};
    tbl[2]  = '{0, 8'h00, 1, 1, 0, 8'hA5};
    tbl[3]  = '{1, 8'h3C, 1, 1, 0, 8'hA5};
    tbl[4]  = '{0, 8'h00, 1, 1, 0, 8'hA5};
    tbl[5]  = '{0, 8'h00, 0, 1, 0, 8'hA5};
    tbl[6]  = '{0, 8'h00, 1, 0, 0, 8'hA5};
    tbl[7]  = '{0, 8'h00, 1, 1, 1, 8'h3C};
    tbl[8]  = '{0, 8'h00, 1, 0, 1, 8'h3C};
    tbl[9]  = '{0, 8'h00, 0, 1, 0, 8'h3C};
    tbl[10] = '{0, 8'h00, 0, 1, 0, 8'h3C};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 0);
    chk("rst_data", data, 0);
    chk("rst_overflow", ovf, 0);
    rst = 0;
    // latency, single pulse, holdoff, and i_en freeze
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].n, tbl[i].e, 0);
      chk($sformatf("vec%0d_ready", i), ready, tbl[i].r);
      chk($sformatf("vec%0d_data", i), data, tbl[i].od);
    end
    // fill, overflow, set-over-clear priority, drain in order
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 1, 0);
    step(1, 8'h10, 0, 1, 0);
    step(1, 8'h11, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 0);
    chk("present_full", ready, 1);
    step(1, 8'h77, 1, 1, 0);
    chk("pop_no_room", ovf, 1);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0);
    end
    chk("drained", sb.size(), 0);
    // interleaved writes and pops so both pointers wrap
    for (int i = 0; i < 20; i++) step(1, 8'(i), i % 3 != 2, 1, 0);
    for (int k = 0; k < 200 && (sb.size() > 0 || ready); k++) step(0, 0, k % 3 != 2, 1, 0);
    chk("wrap_drained", sb.size(), 0);
    chk("wrap_empty", empty, 1);
    // freeze in PRESENT, then async reset mid-handshake
    step(0, 0, 0, 1, 0);
    step(1, 8'h5A, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("frz_ready0", ready, 1);
    step(1, 8'h6B, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("frz_ready1", ready, 1);
    chk("frz_count", count, 2);
    rst = 1;
    #1;
    chk("arst_ready", ready, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_data", data, 0);
    @(posedge clk); #1;
    rst = 0;
    occ = 0; exp_ovf = 0; sb.delete();
    step(1, 8'hC3, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_data", data, 8'hC3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
